// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - b_in, DIGIT bits per clock from LSB
// to MSB through a registered borrow chain. start/busy/done handshake; the
// result, borrow-out and signed-overflow flag are held until the next done.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets where the digits do not tile the operand exactly.
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow;
    logic [CW-1:0]    step;

    logic [DIGIT:0]   dig_sum;
    logic [DIGIT-1:0] d_dig;
    logic             borrow_nxt;
    logic             ovf_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_step;

    // One digit of the borrow chain plus the shifted result it produces.
    // NOTE: every combinational output gets a value on every path before any
    // conditional logic, so no latch can be inferred.
    always_comb begin
        dig_sum    = {1'b0, a_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]}
                     - (DIGIT+1)'(borrow);
        d_dig      = dig_sum[DIGIT-1:0];
        borrow_nxt = dig_sum[DIGIT];
        res_nxt    = (res_reg >> DIGIT) | (WIDTH'(d_dig) << (WIDTH - DIGIT));
        // The MSB sum bit is a^b^borrow_into_msb, so xoring a and b back out
        // recovers the borrow into the MSB; xor with borrow-out gives overflow.
        ovf_nxt    = d_dig[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ borrow_nxt;
        last_step  = (step == CW'(N - 1));
    end

    // Handshake FSM and datapath registers; outputs load only on the final step.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like hardware flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            borrow  <= 1'b0;
            step    <= '0;
            done    <= 1'b0;
            diff    <= '0;
            b_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        borrow  <= b_in;
                        res_reg <= '0;
                        step    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    res_reg <= res_nxt;
                    borrow  <= borrow_nxt;
                    step    <= step + CW'(1);
                    if (last_step) begin
                        diff  <= res_nxt;
                        b_out <= borrow_nxt;
                        ovf   <= ovf_nxt;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: three instances (8/1, 8/4, 4/2) checked
// every cycle against an arithmetic model, plus hand-computed vectors.
module tb_serial_subtractor;

    localparam int NDUT = 3;
    localparam int W_OF [NDUT] = '{8, 8, 4};
    localparam int N_OF [NDUT] = '{8, 2, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_s [NDUT];
    logic [7:0] a_s     [NDUT];
    logic [7:0] b_s     [NDUT];
    logic       bin_s   [NDUT];
    logic       busy_o  [NDUT];
    logic       done_o  [NDUT];
    logic [7:0] diff_o  [NDUT];
    logic       bo_o    [NDUT];
    logic       ov_o    [NDUT];
    logic [3:0] diff2;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .b_in(bin_s[0]), .busy(busy_o[0]), .done(done_o[0]), .diff(diff_o[0]),
        .b_out(bo_o[0]), .ovf(ov_o[0]));

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .b_in(bin_s[1]), .busy(busy_o[1]), .done(done_o[1]), .diff(diff_o[1]),
        .b_out(bo_o[1]), .ovf(ov_o[1]));

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2][3:0]), .b(b_s[2][3:0]),
        .b_in(bin_s[2]), .busy(busy_o[2]), .done(done_o[2]), .diff(diff2),
        .b_out(bo_o[2]), .ovf(ov_o[2]));

    assign diff_o[2] = {4'b0, diff2};

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] ref_diff(input int w, input logic [7:0] a, input logic [7:0] b,
                                            input logic bin);
        int m = (1 << w) - 1;
        int r = (int'(a) & m) - (int'(b) & m) - int'(bin);
        return 8'(r & m);
    endfunction

    function automatic logic ref_bout(input int w, input logic [7:0] a, input logic [7:0] b,
                                      input logic bin);
        int m = (1 << w) - 1;
        return (int'(a) & m) < ((int'(b) & m) + int'(bin));
    endfunction

    function automatic logic ref_ovf(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic bin);
        int m  = (1 << w) - 1;
        int sa = int'(a) & m;
        int sb = int'(b) & m;
        int sr;
        if (sa >= (1 << (w - 1))) sa -= (1 << w);
        if (sb >= (1 << (w - 1))) sb -= (1 << w);
        sr = sa - sb - int'(bin);
        return (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
    endfunction

    // ---------------- behavioural model: countdown per instance ----------------
    int         m_left [NDUT];
    logic       m_done [NDUT];
    logic [7:0] m_diff [NDUT];
    logic       m_bo   [NDUT];
    logic       m_ov   [NDUT];
    logic [7:0] p_diff [NDUT];
    logic       p_bo   [NDUT];
    logic       p_ov   [NDUT];

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
                m_diff[i] <= '0;
                m_bo[i]   <= 1'b0;
                m_ov[i]   <= 1'b0;
            end else begin
                m_done[i] <= (m_left[i] == 1);
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_diff[i] <= p_diff[i];
                        m_bo[i]   <= p_bo[i];
                        m_ov[i]   <= p_ov[i];
                    end
                end else if (start_s[i]) begin
                    p_diff[i] <= ref_diff(W_OF[i], a_s[i], b_s[i], bin_s[i]);
                    p_bo[i]   <= ref_bout(W_OF[i], a_s[i], b_s[i], bin_s[i]);
                    p_ov[i]   <= ref_ovf(W_OF[i], a_s[i], b_s[i], bin_s[i]);
                    m_left[i] <= N_OF[i];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("d%0d busy", i), 32'(busy_o[i]), 32'(m_left[i] != 0));
                check($sformatf("d%0d done", i), 32'(done_o[i]), 32'(m_done[i]));
                check($sformatf("d%0d diff", i), 32'(diff_o[i]), 32'(m_diff[i]));
                check($sformatf("d%0d b_out", i), 32'(bo_o[i]), 32'(m_bo[i]));
                check($sformatf("d%0d ovf", i), 32'(ov_o[i]), 32'(m_ov[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (!done_o[i] && lat < 60) begin
            step();
            lat++;
        end
        check($sformatf("d%0d done within bound", i), 32'(done_o[i]), 32'd1);
    endtask

    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat);
        a_s[i]     = a;
        b_s[i]     = b;
        bin_s[i]   = bin;
        start_s[i] = 1'b1;
        step();
        start_s[i] = 1'b0;
        a_s[i]     = 8'($urandom);
        b_s[i]     = 8'($urandom);
        bin_s[i]   = 1'($urandom);
        wait_done(i, lat);
    endtask

    task automatic expect_result(input string tag, input int i, input int lat, input int exp_lat,
                                 input logic [7:0] d, input logic bo, input logic ov);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " diff"}, 32'(diff_o[i]), 32'(d));
        check({tag, " b_out"}, 32'(bo_o[i]), 32'(bo));
        check({tag, " ovf"}, 32'(ov_o[i]), 32'(ov));
        check({tag, " busy low"}, 32'(busy_o[i]), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs [5] = '{
        '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0},
        '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < NDUT; i++) begin
            start_s[i] = 1'b0;
            a_s[i]     = '0;
            b_s[i]     = '0;
            bin_s[i]   = 1'b0;
        end

        // Reset state, with start asserted to show reset wins.
        start_s[0] = 1'b1;
        step();
        step();
        start_s[0] = 1'b0;
        checking = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset d%0d busy", i), 32'(busy_o[i]), 32'd0);
            check($sformatf("reset d%0d done", i), 32'(done_o[i]), 32'd0);
            check($sformatf("reset d%0d diff", i), 32'(diff_o[i]), 32'd0);
            check($sformatf("reset d%0d b_out", i), 32'(bo_o[i]), 32'd0);
            check($sformatf("reset d%0d ovf", i), 32'(ov_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        step();

        // Directed vectors, WIDTH=8 DIGIT=1.
        foreach (vecs[k]) begin
            run_op(0, vecs[k].a, vecs[k].b, vecs[k].bin, lat);
            expect_result($sformatf("vec%0d", k), 0, lat, 8, vecs[k].d, vecs[k].bo, vecs[k].ov);
            step();
        end

        // Start during busy is ignored.
        a_s[0] = 8'h10; b_s[0] = 8'h01; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        step();
        a_s[0] = 8'hFF; b_s[0] = 8'h00; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        wait_done(0, lat);
        expect_result("ignored start", 0, lat + 3, 8, 8'h0F, 1'b0, 1'b0);

        // Start in the done cycle is accepted immediately.
        a_s[0] = 8'h44; b_s[0] = 8'h11; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        check("done-cycle start busy", 32'(busy_o[0]), 32'd1);
        check("done-cycle start held diff", 32'(diff_o[0]), 32'h0F);
        wait_done(0, lat);
        expect_result("done-cycle start", 0, lat, 8, 8'h33, 1'b0, 1'b0);

        // Reset in busy cycle 4 aborts with no done pulse.
        step();
        a_s[0] = 8'h35; b_s[0] = 8'h12; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid reset busy", 32'(busy_o[0]), 32'd0);
        check("mid reset done", 32'(done_o[0]), 32'd0);
        check("mid reset diff", 32'(diff_o[0]), 32'd0);
        check("mid reset b_out", 32'(bo_o[0]), 32'd0);
        check("mid reset ovf", 32'(ov_o[0]), 32'd0);
        repeat (10) step();
        run_op(0, 8'h80, 8'h01, 1'b0, lat);
        expect_result("after reset", 0, lat, 8, 8'h7F, 1'b0, 1'b1);

        // WIDTH=8 DIGIT=4.
        run_op(1, 8'hA3, 8'h5C, 1'b1, lat);
        expect_result("digit4", 1, lat, 2, 8'h46, 1'b0, 1'b1);

        // Exhaustive WIDTH=4 DIGIT=2; values checked each cycle by the model.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    run_op(2, 8'(av), 8'(bv), 1'(cv), lat);
                    check($sformatf("exh %0h-%0h-%0d latency", av, bv, cv), 32'(lat), 32'd2);
                end
            end
        end

        // Randomised concurrent traffic on all instances.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                start_s[i] = ($urandom_range(0, 2) == 0);
                a_s[i]     = 8'($urandom);
                b_s[i]     = 8'($urandom);
                bin_s[i]   = 1'($urandom);
            end
            step();
        end
        for (int i = 0; i < NDUT; i++) start_s[i] = 1'b0;
        repeat (12) step();

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
